// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, default frame
// header byte and the bit positions inside the TGT byte.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TGT,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CKSUM,
    ST_RUN,
    ST_ERROR
  } bl_state_e;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         TGT_SEL_BIT = 0;
  localparam int         TGT_RUN_BIT = 1;

  function automatic logic is_busy_state(input bl_state_e s);
    return s inside {ST_TGT, ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CKSUM};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Host byte stream (valid/ready) plus the memory write port of the boot loader.
interface boot_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Frame-driven loader: parses HDR/TGT/CNT/data/CK frames from a byte stream,
// writes little-endian words into imem or dmem, and releases the CPU reset.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] HDR    = HDR_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  boot_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         err
);

  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  bl_state_e         state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              run_q, run_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [7:0]        ck_q, ck_d;

  logic              accept;
  logic [16:0]       cnt_full;

  assign accept   = bus.in_valid && in_ready_q;
  assign cnt_full = {1'b0, bus.in_data, cnt_lo_q};

  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    err_d        = err_q;
    run_d        = run_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    shreg_d      = shreg_q;
    ck_d         = ck_q;

    // Step past the word just written unless it was the last one, so the
    // address never wraps after a full-size load.
    if (mem_we_q && (words_left_q != '0)) begin
      mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    if (accept) begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (bus.in_data == HDR) begin
            state_d = ST_TGT;
            err_d   = 1'b0;
            ck_d    = 8'h00;
          end
        end
        ST_TGT: begin
          ck_d = ck_q ^ bus.in_data;
          if (bus.in_data[7:2] != 6'd0) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            mem_sel_d = bus.in_data[TGT_SEL_BIT];
            run_d     = bus.in_data[TGT_RUN_BIT];
            state_d   = ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          ck_d     = ck_q ^ bus.in_data;
          cnt_lo_d = bus.in_data;
          state_d  = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          ck_d = ck_q ^ bus.in_data;
          if (cnt_full == 17'd0) begin
            state_d = ST_CKSUM;
          end else if (cnt_full > MAX_WORDS) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d      = ST_DATA;
            mem_addr_d   = '0;
            words_left_d = cnt_full[ADDR_W:0];
            byte_idx_d   = 2'd0;
          end
        end
        ST_DATA: begin
          ck_d       = ck_q ^ bus.in_data;
          shreg_d    = {bus.in_data, shreg_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_we_d     = 1'b1;
            mem_wdata_d  = {bus.in_data, shreg_q};
            words_left_d = words_left_q - WL_ONE;
            if (words_left_q == WL_ONE) begin
              state_d = ST_CKSUM;
            end
          end
        end
        ST_CKSUM: begin
          if (bus.in_data == ck_q) begin
            if (run_q) begin
              state_d     = ST_RUN;
              cpu_reset_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d     = is_busy_state(state_d);
    in_ready_d = (state_d != ST_RUN) && !mem_we_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      run_q        <= 1'b0;
      cnt_lo_q     <= 8'd0;
      words_left_q <= '0;
      byte_idx_q   <= 2'd0;
      shreg_q      <= 24'd0;
      ck_q         <= 8'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      run_q        <= run_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      shreg_q      <= shreg_d;
      ck_q         <= ck_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule
